invsqrt_seq_ctrl: RTL and testbench

- Sequencer for the fast inverse-square-root datapath.
- Accepts one IEEE-754 single-precision operand per transaction over a valid/ready handshake.
- Forms the magic-constant seed y0 and half-input h internally, then runs NITER Newton-Raphson refinements y = y*(1.5 - h*y*y).
- Each refinement is issued as a sequence of operations to one shared external FP unit (mul/sub) through a req/ack port; results return on a valid/ready output.

---
 rtl/invsqrt_seq_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_invsqrt_seq_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/invsqrt_seq_ctrl.sv
// Sequencer for a fast inverse-square-root: magic-constant seed followed by NITER Newton-Raphson
// refinements, each issued as mul/mul/sub/mul operations to a shared external FP unit.
module invsqrt_seq_ctrl #(
    parameter logic [31:0] MAGIC     = 32'h5f3759df,
    parameter int unsigned NITER     = 1,
    parameter logic [31:0] THREEHALF = 32'h3FC00000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_err,
    output logic        op_req,
    output logic        op_sel,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    input  logic        op_ack,
    input  logic [31:0] op_res
);

    localparam logic [3:0] IterLast = 4'(NITER);

    localparam logic [31:0] QNan   = 32'h7FC00000;
    localparam logic [31:0] PosInf = 32'h7F800000;

    typedef enum logic [2:0] {
        StIdle,
        StSeed,
        StYy,
        StHyy,
        StSub,
        StUpd,
        StOut
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] x_q, x_d;
    logic [31:0] y_q, y_d;
    logic [31:0] h_q, h_d;
    logic [31:0] t_q, t_d;
    logic [3:0]  iter_q, iter_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_err_q, out_err_d;

    logic [31:0] seed_y;
    logic [31:0] seed_h;
    logic [3:0]  iter_inc;
    logic        is_special;
    logic [31:0] special_val;

    // Halving x is done by decrementing the exponent; only meaningful for normal operands.
    assign seed_y   = MAGIC - {1'b0, x_q[31:1]};
    assign seed_h   = {1'b0, x_q[30:23] - 8'd1, x_q[22:0]};
    assign iter_inc = iter_q + 4'd1;

    // Order matters: -0 must be caught as zero before the negative-operand rule.
    always_comb begin
        is_special  = 1'b1;
        special_val = QNan;
        if (x_q[30:0] == 31'd0) begin
            special_val = PosInf;
        end else if (x_q[31]) begin
            special_val = QNan;
        end else if (x_q[30:23] == 8'hFF && x_q[22:0] != 23'd0) begin
            special_val = QNan;
        end else if (x_q[30:23] == 8'hFF) begin
            special_val = 32'h0000_0000;
        end else if (x_q[30:23] == 8'h00) begin
            special_val = PosInf;
        end else begin
            is_special = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        h_d        = h_q;
        t_d        = t_q;
        iter_d     = iter_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        op_req     = 1'b0;
        op_sel     = 1'b0;
        op_a       = 32'd0;
        op_b       = 32'd0;

        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    x_d     = in_data;
                    state_d = StSeed;
                end
            end
            StSeed: begin
                y_d    = seed_y;
                h_d    = seed_h;
                iter_d = 4'd0;
                if (is_special) begin
                    out_data_d = special_val;
                    out_err_d  = 1'b1;
                    state_d    = StOut;
                end else if (NITER == 0) begin
                    out_data_d = seed_y;
                    out_err_d  = 1'b0;
                    state_d    = StOut;
                end else begin
                    state_d = StYy;
                end
            end
            StYy: begin
                op_req = 1'b1;
                op_a   = y_q;
                op_b   = y_q;
                if (op_ack) begin
                    t_d     = op_res;
                    state_d = StHyy;
                end
            end
            StHyy: begin
                op_req = 1'b1;
                op_a   = h_q;
                op_b   = t_q;
                if (op_ack) begin
                    t_d     = op_res;
                    state_d = StSub;
                end
            end
            StSub: begin
                op_req = 1'b1;
                op_sel = 1'b1;
                op_a   = THREEHALF;
                op_b   = t_q;
                if (op_ack) begin
                    t_d     = op_res;
                    state_d = StUpd;
                end
            end
            StUpd: begin
                op_req = 1'b1;
                op_a   = y_q;
                op_b   = t_q;
                if (op_ack) begin
                    y_d    = op_res;
                    iter_d = iter_inc;
                    if (iter_inc == IterLast) begin
                        out_data_d = op_res;
                        out_err_d  = 1'b0;
                        state_d    = StOut;
                    end else begin
                        state_d = StYy;
                    end
                end
            end
            StOut: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            x_q        <= 32'd0;
            y_q        <= 32'd0;
            h_q        <= 32'd0;
            t_q        <= 32'd0;
            iter_q     <= 4'd0;
            out_data_q <= 32'd0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            h_q        <= h_d;
            t_q        <= t_d;
            iter_q     <= iter_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
        end
    end

    assign out_data = out_data_q;
    assign out_err  = out_err_q;

endmodule

// File: tb/tb_invsqrt_seq_ctrl.sv
// Scoreboard bench: three sequencers (NITER = 0, 1, 2) each paired with a behavioural FP unit
// whose ack delay is programmable; a monitor pops expected results as outputs appear.
module tb_invsqrt_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always_ff @(posedge clk) cyc <= cyc + 1;

    logic [2:0]  in_valid, out_ready;
    logic [31:0] in_data [3];
    wire  [2:0]  in_ready, out_valid, out_err, op_req, op_sel, op_ack;
    wire  [31:0] out_data [3];
    wire  [31:0] op_a [3];
    wire  [31:0] op_b [3];
    wire  [31:0] op_res [3];

    int ack_delay = 0;
    int vectors = 0;
    int miscompares = 0;

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) d = {f[31], 63'd0};
        else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [24:0] m;
        int e;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        m = {2'b01, d[51:29]} + 25'(d[28]);
        if (m[24]) begin
            m = m >> 1;
            e = e + 1;
        end
        if (d[62:52] == 11'd0 || e <= 0) return {d[63], 31'd0};
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        return {d[63], e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] fp_op(input logic sel, input logic [31:0] a, input logic [31:0] b);
        if (sel) return r2f(f2r(a) - f2r(b));
        return r2f(f2r(a) * f2r(b));
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        int wcnt;

        invsqrt_seq_ctrl #(
            .NITER(g)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_data  (in_data[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_data (out_data[g]),
            .out_err  (out_err[g]),
            .op_req   (op_req[g]),
            .op_sel   (op_sel[g]),
            .op_a     (op_a[g]),
            .op_b     (op_b[g]),
            .op_ack   (op_ack[g]),
            .op_res   (op_res[g])
        );

        // Ack after ack_delay waiting cycles; counter restarts after every ack.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) wcnt <= 0;
            else if (op_req[g] && !op_ack[g]) wcnt <= wcnt + 1;
            else wcnt <= 0;
        end
        assign op_ack[g] = op_req[g] && (wcnt >= ack_delay);
        assign op_res[g] = fp_op(op_sel[g], op_a[g], op_b[g]);
    end

    typedef struct {
        logic [31:0] data;
        logic        err;
        real         tol;
        real         refv;
        int          exp_cyc;
        int          op_base;
        int          exp_ops;
    } exp_t;

    typedef struct {
        logic        sel;
        logic [31:0] a;
    } op_t;

    exp_t sb [$];
    op_t  opq [$];
    int   op_cnt [3] = '{0, 0, 0};
    int   last_hs [3] = '{0, 0, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: operand stability, op ordering on DUT1, latency, op count and results.
    logic [2:0]  prev_req = '0, prev_ack = '0, prev_sel = '0, prev_ov = '0;
    logic [31:0] prev_a [3];
    logic [31:0] prev_b [3];
    always @(negedge clk) begin
        exp_t e;
        op_t  o;
        real  got, rel;
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                prev_req[d] = 1'b0;
                prev_ack[d] = 1'b0;
                prev_ov[d]  = 1'b0;
            end else begin
                if (prev_req[d] && !prev_ack[d]) begin
                    check("op_req held", 32'(op_req[d]), 32'd1);
                    check("op_sel held", 32'(op_sel[d]), 32'(prev_sel[d]));
                    check("op_a held", op_a[d], prev_a[d]);
                    check("op_b held", op_b[d], prev_b[d]);
                end
                if (op_req[d] && op_ack[d]) begin
                    op_cnt[d]++;
                    if (d == 1 && opq.size() > 0) begin
                        o = opq.pop_front();
                        check("op order sel", 32'(op_sel[d]), 32'(o.sel));
                        check("op order a", op_a[d], o.a);
                    end
                end
                if (out_valid[d]) begin
                    if (sb.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected output: dut %0d got %h, expected none", d, out_data[d]);
                    end else begin
                        e = sb[0];
                        if (!prev_ov[d]) begin
                            check("out latency", 32'(cyc), 32'(e.exp_cyc));
                            check("op count", 32'(op_cnt[d] - e.op_base), 32'(e.exp_ops));
                        end
                        if (e.tol == 0.0) begin
                            check("out_data", out_data[d], e.data);
                        end else begin
                            got = f2r(out_data[d]);
                            rel = (got - e.refv) / e.refv;
                            if (rel < 0.0) rel = -rel;
                            vectors++;
                            if (rel > e.tol) begin
                                miscompares++;
                                $display("FAIL out_data approx: got %h (%g), expected %g within rel %g",
                                         out_data[d], got, e.refv, e.tol);
                            end
                        end
                        check("out_err", 32'(out_err[d]), 32'(e.err));
                        check("in_ready while busy", 32'(in_ready[d]), 32'd0);
                        if (out_ready[d]) begin
                            void'(sb.pop_front());
                            last_hs[d] = cyc;
                        end
                    end
                end
                prev_req[d] = op_req[d];
                prev_ack[d] = op_ack[d];
                prev_sel[d] = op_sel[d];
                prev_ov[d]  = out_valid[d];
                prev_a[d]   = op_a[d];
                prev_b[d]   = op_b[d];
            end
        end
    end

    task automatic send(input int d, input logic [31:0] x, input logic [31:0] expd, input logic experr,
                        input real tol, input real refv, input int nops, input int dly,
                        output int t_acc);
        exp_t e;
        @(negedge clk);
        in_valid[d] = 1'b1;
        in_data[d]  = x;
        t_acc = -1;
        for (int i = 0; i < 300; i++) begin
            if (in_ready[d]) begin
                t_acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (t_acc < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL accept timeout: dut %0d in_ready stayed 0, expected 1", d);
            in_valid[d] = 1'b0;
        end else begin
            e.data    = expd;
            e.err     = experr;
            e.tol     = tol;
            e.refv    = refv;
            e.exp_cyc = t_acc + 2 + nops * (dly + 1);
            e.op_base = op_cnt[d];
            e.exp_ops = nops;
            sb.push_back(e);
            @(posedge clk);
            #1 in_valid[d] = 1'b0;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (sb.size() == 0) return;
            @(negedge clk);
        end
        vectors++;
        miscompares++;
        $display("FAIL result timeout: %0d results outstanding, expected 0", sb.size());
        sb.delete();
    endtask

    task automatic push_ops_x4();
        op_t o;
        o.sel = 1'b0; o.a = 32'h3EF759DF; opq.push_back(o);
        o.sel = 1'b0; o.a = 32'h40000000; opq.push_back(o);
        o.sel = 1'b1; o.a = 32'h3FC00000; opq.push_back(o);
        o.sel = 1'b0; o.a = 32'h3EF759DF; opq.push_back(o);
    endtask

    logic [31:0] spec_x [6] = '{32'h00000000, 32'hBF800000, 32'h7F800000,
                                32'h7FC00001, 32'h00000001, 32'h80000000};
    logic [31:0] spec_y [6] = '{32'h7F800000, 32'h7FC00000, 32'h00000000,
                                32'h7FC00000, 32'h7F800000, 32'h7F800000};
    logic [31:0] nr_x [3] = '{32'h40000000, 32'h42C80000, 32'h1E3CE508};

    initial begin
        int t, t2;
        bit found;
        in_valid  = '0;
        out_ready = '1;
        for (int d = 0; d < 3; d++) in_data[d] = 32'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("reset in_ready", 32'(in_ready[d]), 32'd1);
            check("reset out_valid", 32'(out_valid[d]), 32'd0);
            check("reset out_err", 32'(out_err[d]), 32'd0);
            check("reset out_data", out_data[d], 32'd0);
            check("reset op_req", 32'(op_req[d]), 32'd0);
            check("reset op_a", op_a[d], 32'd0);
            check("reset op_b", op_b[d], 32'd0);
        end
        rst_n = 1'b1;

        // Seed only: 0x5f3759df - (0x40800000 >> 1).
        send(0, 32'h40800000, 32'h3EF759DF, 1'b0, 0.0, 0.0, 0, 0, t);
        wait_idle();

        for (int i = 0; i < 6; i++) send(1, spec_x[i], spec_y[i], 1'b1, 0.0, 0.0, 0, 0, t);
        wait_idle();

        push_ops_x4();
        send(1, 32'h40800000, 32'h0, 1'b0, 0.002, 0.5, 4, 0, t);
        wait_idle();
        check("op queue drained", 32'(opq.size()), 32'd0);

        ack_delay = 3;
        for (int i = 0; i < 3; i++)
            send(2, nr_x[i], 32'h0, 1'b0, 1.0e-5, 1.0 / $sqrt(f2r(nr_x[i])), 8, 3, t);
        wait_idle();
        ack_delay = 0;

        // Backpressure: hold out_ready low while a second operand waits.
        out_ready[0] = 1'b0;
        send(0, 32'h40800000, 32'h3EF759DF, 1'b0, 0.0, 0.0, 0, 0, t);
        fork
            begin
                for (int i = 0; i < 50; i++) begin
                    if (out_valid[0]) break;
                    @(negedge clk);
                end
                repeat (5) @(posedge clk);
                #1 out_ready[0] = 1'b1;
            end
            send(0, 32'h00000000, 32'h7F800000, 1'b1, 0.0, 0.0, 0, 0, t2);
        join
        check("accept after out handshake", 32'(t2), 32'(last_hs[0] + 1));
        wait_idle();

        // Reset while DUT1 waits on its HYY op.
        ack_delay = 2;
        send(1, 32'h40800000, 32'h0, 1'b0, 0.002, 0.5, 4, 2, t);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (op_req[1] && op_a[1] == 32'h40000000) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reached HYY", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("op_req in reset", 32'(op_req[1]), 32'd0);
        check("out_valid in reset", 32'(out_valid[1]), 32'd0);
        sb.delete();
        opq.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        #1 check("in_ready after reset", 32'(in_ready[1]), 32'd1);
        ack_delay = 0;
        push_ops_x4();
        send(1, 32'h40800000, 32'h0, 1'b0, 0.002, 0.5, 4, 0, t);
        wait_idle();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
